pipe_ctrl: RTL and testbench

Pipeline interlock controller for the five-stage R/I/J CPU. It acts on the load-use hazard flag from the hazard detector, on taken branches resolved in EX, and on data-memory wait. It drives the PC and pipeline-register write enables and clears: one bubble for load-use, a two-slot flush for taken branches, and a full freeze for memory wait. It also keeps saturating event counters, a memory-wait watchdog and a sticky protocol-error flag for debug.

---
 rtl/pipe_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Brief    : Pipeline interlock controller for the five-stage R/I/J CPU.
//             Turns load-use hazards, taken branches and data-memory wait
//             into PC / pipeline-register enables and clears. It also keeps
//             saturating event counters, a memory-wait watchdog and a sticky
//             protocol-error flag.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_clr,
    output logic             idex_we,
    output logic             idex_clr,
    output logic             exmem_we,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             mem_timeout,
    output logic             proto_err
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2,
        S_WAIT  = 2'd3
    } act_t;

    // The watchdog run counter only needs to reach WAIT_MAX+1 and hold there.
    localparam int               c_RUN_W   = $clog2(WAIT_MAX + 2);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] c_CNT_SAT = {CNT_W{1'b1}};

    act_t               w_act;
    act_t               r_state;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [c_RUN_W-1:0] r_run;
    logic               r_mem_timeout;
    logic               r_proto_err;

    // Pick the single action for this cycle: mem_busy > branch_taken > hazard.
    always_comb begin
        w_act = S_RUN;
        if (mem_busy)
            w_act = S_WAIT;
        else if (branch_taken)
            w_act = S_FLUSH;
        else if (hazard)
            w_act = S_STALL;
    end

    // Zero-latency enables/clears; reset holds the pipeline full of NOPs.
    always_comb begin
        pc_we    = 1'b1;
        ifid_we  = 1'b1;
        ifid_clr = 1'b0;
        idex_we  = 1'b1;
        idex_clr = 1'b0;
        exmem_we = 1'b1;
        if (rst) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            ifid_clr = 1'b1;
            idex_we  = 1'b0;
            idex_clr = 1'b1;
            exmem_we = 1'b0;
        end else begin
            case (w_act)
                S_WAIT: begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    idex_we  = 1'b0;
                    exmem_we = 1'b0;
                end
                S_FLUSH: begin
                    ifid_clr = 1'b1;
                    idex_clr = 1'b1;
                end
                S_STALL: begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    idex_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Record the action taken, count events, run the watchdog and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_run         <= '0;
            r_mem_timeout <= 1'b0;
            r_proto_err   <= 1'b0;
        end else begin
            r_state <= w_act;
            case (w_act)
                S_STALL: begin
                    if (r_stall_cnt != c_CNT_SAT)
                        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                    // Back-to-back stalls mean the hazard detector did not
                    // see the bubble; a WAIT in between resets the check.
                    if (r_state == S_STALL)
                        r_proto_err <= 1'b1;
                end
                S_FLUSH: begin
                    if (r_flush_cnt != c_CNT_SAT)
                        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
                end
                S_WAIT: begin
                    if (r_wait_cnt != c_CNT_SAT)
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                end
                default: ;
            endcase
            if (mem_busy) begin
                if (r_run != c_RUN_MAX)
                    r_run <= r_run + c_RUN_W'(1);
                // This edge completes busy cycle r_run+1; flag once it exceeds WAIT_MAX.
                if (r_run >= c_RUN_W'(WAIT_MAX))
                    r_mem_timeout <= 1'b1;
            end else begin
                r_run <= '0;
            end
        end
    end

    assign state       = r_state;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign wait_cnt    = r_wait_cnt;
    assign mem_timeout = r_mem_timeout;
    assign proto_err   = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Brief    : Self-checking bench for pipe_ctrl: a vector table for the
//             per-cycle action decode plus directed multi-cycle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    // Control vector order: {pc_we, ifid_we, ifid_clr, idex_we, idex_clr, exmem_we}
    localparam logic [5:0] c_RUN   = 6'b110101;
    localparam logic [5:0] c_STALL = 6'b000111;
    localparam logic [5:0] c_FLUSH = 6'b111111;
    localparam logic [5:0] c_WAIT  = 6'b000000;
    localparam logic [5:0] c_RST   = 6'b001010;

    logic        clk = 1'b0;
    logic        rst, hazard, branch_taken, mem_busy;
    logic        pc_we, ifid_we, ifid_clr, idex_we, idex_clr, exmem_we;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt, wait_cnt;
    logic        mem_timeout, proto_err;
    logic        s_pc_we, s_ifid_we, s_ifid_clr, s_idex_we, s_idex_clr, s_exmem_we;
    logic [1:0]  s_state;
    logic [3:0]  s_stall_cnt, s_flush_cnt, s_wait_cnt;
    logic        s_mem_timeout, s_proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32), .WAIT_MAX(15)) u_dut (
        .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_clr(ifid_clr), .idex_we(idex_we), .idex_clr(idex_clr),
        .exmem_we(exmem_we), .state(state), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .wait_cnt(wait_cnt),
        .mem_timeout(mem_timeout), .proto_err(proto_err)
    );

    // Narrow-counter instance for the saturation check; same stimulus.
    pipe_ctrl #(.CNT_W(4), .WAIT_MAX(15)) u_dut_sat (
        .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_we(s_pc_we), .ifid_we(s_ifid_we),
        .ifid_clr(s_ifid_clr), .idex_we(s_idex_we), .idex_clr(s_idex_clr),
        .exmem_we(s_exmem_we), .state(s_state), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt), .wait_cnt(s_wait_cnt),
        .mem_timeout(s_mem_timeout), .proto_err(s_proto_err)
    );

    typedef struct {
        logic       r, h, b, m;
        logic [5:0] exp_ctrl;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [5:0] ctrl();
        return {pc_we, ifid_we, ifid_clr, idex_we, idex_clr, exmem_we};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic h, input logic b, input logic m);
        rst = r; hazard = h; branch_taken = b; mem_busy = m;
        #1;
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, c_RST,   2'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, c_RST,   2'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, c_RUN,   2'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, c_STALL, 2'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, c_RUN,   2'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, c_FLUSH, 2'd2};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, c_WAIT,  2'd3};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, c_WAIT,  2'd3};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, c_STALL, 2'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, c_FLUSH, 2'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, c_WAIT,  2'd3};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, c_STALL, 2'd1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, c_RUN,   2'd0};

        tick();
        // Table: decode of each cycle and the state recorded at the edge.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].r, vecs[i].h, vecs[i].b, vecs[i].m);
            chk($sformatf("vec%0d_ctrl", i), 64'(ctrl()), 64'(vecs[i].exp_ctrl));
            tick();
            chk($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].exp_state));
        end
        chk("tbl_stall_cnt", 64'(stall_cnt), 64'd3);
        chk("tbl_flush_cnt", 64'(flush_cnt), 64'd2);
        chk("tbl_wait_cnt",  64'(wait_cnt),  64'd3);
        chk("tbl_proto_err", 64'(proto_err), 64'd0);
        chk("tbl_timeout",   64'(mem_timeout), 64'd0);

        // Reset clears everything, then three idle cycles stay in RUN.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            chk("idle_ctrl", 64'(ctrl()), 64'(c_RUN));
            tick();
        end
        chk("idle_state", 64'(state), 64'd0);
        chk("idle_cnts", {stall_cnt, flush_cnt | wait_cnt}, 64'd0);

        // Single hazard: one bubble, then RUN with state==STALL on entry.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("hz1_ctrl", 64'(ctrl()), 64'(c_STALL));
        tick();
        chk("hz1_state", 64'(state), 64'd1);
        chk("hz1_stall_cnt", 64'(stall_cnt), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("hz1_run_ctrl", 64'(ctrl()), 64'(c_RUN));
        tick();
        chk("hz1_proto", 64'(proto_err), 64'd0);

        // Two consecutive hazards: protocol error.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("hz2_proto_first", 64'(proto_err), 64'd0);
        tick();
        chk("hz2_proto", 64'(proto_err), 64'd1);
        chk("hz2_stall_cnt", 64'(stall_cnt), 64'd2);

        // Branch wins over hazard.
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("br_hz_ctrl", 64'(ctrl()), 64'(c_FLUSH));
        tick();
        chk("br_hz_flush_cnt", 64'(flush_cnt), 64'd1);
        chk("br_hz_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("br_hz_state", 64'(state), 64'd2);

        // 16 busy cycles with hazard held: watchdog trips on the 16th edge.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("wait%0d_ctrl", i), 64'(ctrl()), 64'(c_WAIT));
            tick();
            if (i == 15) chk("wait15_timeout", 64'(mem_timeout), 64'd0);
        end
        chk("wait16_timeout", 64'(mem_timeout), 64'd1);
        chk("wait16_wait_cnt", 64'(wait_cnt), 64'd16);
        chk("wait16_state", 64'(state), 64'd3);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_wait_ctrl", 64'(ctrl()), 64'(c_STALL));
        tick();
        chk("post_wait_proto", 64'(proto_err), 64'd0);
        chk("post_wait_stall", 64'(stall_cnt), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("timeout_sticky", 64'(mem_timeout), 64'd1);
        // Reset mid-WAIT discards the pending action.
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_mid_ctrl", 64'(ctrl()), 64'(c_RST));
        tick();
        chk("rst_timeout", 64'(mem_timeout), 64'd0);
        chk("rst_wait_cnt", 64'(wait_cnt), 64'd0);
        chk("rst_state", 64'(state), 64'd0);

        // 20 branches: 4-bit counter saturates at 15, 32-bit reaches 20.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_flush_cnt4", 64'(s_flush_cnt), 64'd15);
        chk("sat_flush_cnt32", 64'(flush_cnt), 64'd20);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
